id_ex_pipeline_reg: RTL and testbench

Decode-to-execute pipeline register. It captures the decode-stage outputs on each rising clock edge: control bundle, register-file read data, PC values, register addresses and the sign-extended immediate ImmExtD from the immediate extender. It presents these to the execute stage as *E signals. It supports a hazard-unit stall (hold) and flush (bubble insertion), and carries a ValidE bit so downstream logic can tell real instructions from bubbles.

---
 rtl/riscv_pkg.sv | 48 ++++
 rtl/id_ex_pipeline_reg_if.sv | 55 +++++
 rtl/pipe_reg_en_clr.sv | 36 +++
 rtl/id_ex_pipeline_reg.sv | 101 ++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: datapath widths, writeback-select encodings
// and the control/data bundles carried between pipeline stages.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUCTRL_W  = 3;

    typedef enum logic [1:0] {
        RESULT_ALU = 2'd0,
        RESULT_MEM = 2'd1,
        RESULT_PC4 = 2'd2
    } result_src_e;

    // Stage occupancy, encoded directly by the ValidE bit.
    typedef enum logic {
        ST_BUBBLE = 1'b0,
        ST_VALID  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic                 reg_write;
        result_src_e          result_src;
        logic                 mem_write;
        logic                 jump;
        logic                 branch;
        logic                 alu_src;
        logic [ALUCTRL_W-1:0] alu_control;
        logic [2:0]           funct3;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]       rd1;
        logic [XLEN-1:0]       rd2;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       pc_plus4;
        logic [XLEN-1:0]       imm_ext;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } data_t;

    localparam ctrl_t BUBBLE = '0;

    localparam int CTRL_W = $bits(ctrl_t);
    localparam int DATA_W = $bits(data_t);

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// Decode-to-execute bundle: D-side signals from decode, E-side signals to execute.
interface id_ex_pipeline_reg_if;
    import riscv_pkg::*;

    logic                  ValidD;
    logic                  RegWriteD;
    logic [1:0]            ResultSrcD;
    logic                  MemWriteD;
    logic                  JumpD;
    logic                  BranchD;
    logic                  ALUSrcD;
    logic [ALUCTRL_W-1:0]  ALUControlD;
    logic [2:0]            Funct3D;
    logic [XLEN-1:0]       RD1D;
    logic [XLEN-1:0]       RD2D;
    logic [XLEN-1:0]       PCD;
    logic [XLEN-1:0]       PCPlus4D;
    logic [XLEN-1:0]       ImmExtD;
    logic [REG_ADDR_W-1:0] Rs1D;
    logic [REG_ADDR_W-1:0] Rs2D;
    logic [REG_ADDR_W-1:0] RdD;

    logic                  ValidE;
    logic                  RegWriteE;
    logic [1:0]            ResultSrcE;
    logic                  MemWriteE;
    logic                  JumpE;
    logic                  BranchE;
    logic                  ALUSrcE;
    logic [ALUCTRL_W-1:0]  ALUControlE;
    logic [2:0]            Funct3E;
    logic [XLEN-1:0]       RD1E;
    logic [XLEN-1:0]       RD2E;
    logic [XLEN-1:0]       PCE;
    logic [XLEN-1:0]       PCPlus4E;
    logic [XLEN-1:0]       ImmExtE;
    logic [REG_ADDR_W-1:0] Rs1E;
    logic [REG_ADDR_W-1:0] Rs2E;
    logic [REG_ADDR_W-1:0] RdE;

    modport master (
        output ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
               ALUControlD, Funct3D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        input  ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ALUControlE, Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
    );

    modport slave (
        input  ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
               ALUControlD, Funct3D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        output ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ALUControlE, Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
    );

endinterface

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline flop: async reset, synchronous clear, load enable.
// Clear beats enable so a flush always wins over a stall.
module pipe_reg_en_clr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with hazard-unit stall (hold) and flush (bubble).
// ValidE is the VALID/BUBBLE state of the execute slot.
module id_ex_pipeline_reg
    import riscv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallE,
    input  logic                 FlushE,
    id_ex_pipeline_reg_if.slave  bus
);

    ctrl_t       ctrl_d;
    ctrl_t       ctrl_q;
    data_t       data_d;
    data_t       data_q;
    slot_state_e state_d;
    slot_state_e state_q;
    logic        load_en;

    assign load_en = ~StallE;

    always_comb begin
        ctrl_d             = BUBBLE;
        ctrl_d.reg_write   = bus.RegWriteD;
        ctrl_d.result_src  = result_src_e'(bus.ResultSrcD);
        ctrl_d.mem_write   = bus.MemWriteD;
        ctrl_d.jump        = bus.JumpD;
        ctrl_d.branch      = bus.BranchD;
        ctrl_d.alu_src     = bus.ALUSrcD;
        ctrl_d.alu_control = bus.ALUControlD;
        ctrl_d.funct3      = bus.Funct3D;
    end

    always_comb begin
        data_d          = '0;
        data_d.rd1      = bus.RD1D;
        data_d.rd2      = bus.RD2D;
        data_d.pc       = bus.PCD;
        data_d.pc_plus4 = bus.PCPlus4D;
        data_d.imm_ext  = bus.ImmExtD;
        data_d.rs1      = bus.Rs1D;
        data_d.rs2      = bus.Rs2D;
        data_d.rd       = bus.RdD;
    end

    pipe_reg_en_clr #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load_en),
        .clr   (FlushE),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    pipe_reg_en_clr #(.WIDTH(DATA_W)) u_data_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load_en),
        .clr   (FlushE),
        .d     (data_d),
        .q     (data_q)
    );

    // A load of an invalid decode slot drops back to BUBBLE as well.
    always_comb begin
        state_d = state_q;
        if (FlushE) begin
            state_d = ST_BUBBLE;
        end else if (load_en) begin
            state_d = bus.ValidD ? ST_VALID : ST_BUBBLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BUBBLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.ValidE      = (state_q == ST_VALID);
    assign bus.RegWriteE   = ctrl_q.reg_write;
    assign bus.ResultSrcE  = ctrl_q.result_src;
    assign bus.MemWriteE   = ctrl_q.mem_write;
    assign bus.JumpE       = ctrl_q.jump;
    assign bus.BranchE     = ctrl_q.branch;
    assign bus.ALUSrcE     = ctrl_q.alu_src;
    assign bus.ALUControlE = ctrl_q.alu_control;
    assign bus.Funct3E     = ctrl_q.funct3;
    assign bus.RD1E        = data_q.rd1;
    assign bus.RD2E        = data_q.rd2;
    assign bus.PCE         = data_q.pc;
    assign bus.PCPlus4E    = data_q.pc_plus4;
    assign bus.ImmExtE     = data_q.imm_ext;
    assign bus.Rs1E        = data_q.rs1;
    assign bus.Rs2E        = data_q.rs2;
    assign bus.RdE         = data_q.rd;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: directed hazard scenarios followed by
// randomized stall/flush traffic checked against an abstract slot model.
module tb_id_ex_pipeline_reg;
    import riscv_pkg::*;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic [2:0]  alu_control;
        logic [2:0]  funct3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] imm_ext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } slot_t;

    logic clk = 1'b0;
    logic reset;
    logic StallE;
    logic FlushE;

    id_ex_pipeline_reg_if bus ();

    id_ex_pipeline_reg dut (
        .clk    (clk),
        .reset  (reset),
        .StallE (StallE),
        .FlushE (FlushE),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    slot_t expQ[$];
    slot_t model;
    int    checkCount = 0;
    int    passCount  = 0;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
        checkCount++;
        if (act === req) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic slot_t sampleE();
        slot_t s;
        s.valid       = bus.ValidE;
        s.reg_write   = bus.RegWriteE;
        s.result_src  = bus.ResultSrcE;
        s.mem_write   = bus.MemWriteE;
        s.jump        = bus.JumpE;
        s.branch      = bus.BranchE;
        s.alu_src     = bus.ALUSrcE;
        s.alu_control = bus.ALUControlE;
        s.funct3      = bus.Funct3E;
        s.rd1         = bus.RD1E;
        s.rd2         = bus.RD2E;
        s.pc          = bus.PCE;
        s.pc_plus4    = bus.PCPlus4E;
        s.imm_ext     = bus.ImmExtE;
        s.rs1         = bus.Rs1E;
        s.rs2         = bus.Rs2E;
        s.rd          = bus.RdE;
        return s;
    endfunction

    function automatic slot_t captureD();
        slot_t s;
        s.valid       = bus.ValidD;
        s.reg_write   = bus.RegWriteD;
        s.result_src  = bus.ResultSrcD;
        s.mem_write   = bus.MemWriteD;
        s.jump        = bus.JumpD;
        s.branch      = bus.BranchD;
        s.alu_src     = bus.ALUSrcD;
        s.alu_control = bus.ALUControlD;
        s.funct3      = bus.Funct3D;
        s.rd1         = bus.RD1D;
        s.rd2         = bus.RD2D;
        s.pc          = bus.PCD;
        s.pc_plus4    = bus.PCPlus4D;
        s.imm_ext     = bus.ImmExtD;
        s.rs1         = bus.Rs1D;
        s.rs2         = bus.Rs2D;
        s.rd          = bus.RdD;
        return s;
    endfunction

    task automatic clearD();
        bus.ValidD      = 1'b0;
        bus.RegWriteD   = 1'b0;
        bus.ResultSrcD  = 2'd0;
        bus.MemWriteD   = 1'b0;
        bus.JumpD       = 1'b0;
        bus.BranchD     = 1'b0;
        bus.ALUSrcD     = 1'b0;
        bus.ALUControlD = 3'd0;
        bus.Funct3D     = 3'd0;
        bus.RD1D        = 32'd0;
        bus.RD2D        = 32'd0;
        bus.PCD         = 32'd0;
        bus.PCPlus4D    = 32'd0;
        bus.ImmExtD     = 32'd0;
        bus.Rs1D        = 5'd0;
        bus.Rs2D        = 5'd0;
        bus.RdD         = 5'd0;
    endtask

    task automatic randomD();
        bus.ValidD      = 1'($urandom);
        bus.RegWriteD   = 1'($urandom);
        bus.ResultSrcD  = 2'($urandom_range(0, 2));
        bus.MemWriteD   = 1'($urandom);
        bus.JumpD       = 1'($urandom);
        bus.BranchD     = 1'($urandom);
        bus.ALUSrcD     = 1'($urandom);
        bus.ALUControlD = 3'($urandom);
        bus.Funct3D     = 3'($urandom);
        bus.RD1D        = $urandom;
        bus.RD2D        = $urandom;
        bus.PCD         = $urandom & 32'hFFFF_FFFC;
        bus.PCPlus4D    = bus.PCD + 32'd4;
        bus.ImmExtD     = $urandom;
        bus.Rs1D        = 5'($urandom);
        bus.Rs2D        = 5'($urandom);
        bus.RdD         = 5'($urandom);
    endtask

    // The slot either empties on flush, keeps its instruction on stall, or takes decode's.
    task automatic applyStimulus(input logic stall, input logic flush);
        StallE = stall;
        FlushE = flush;
        if (flush) begin
            model = '0;
        end else if (!stall) begin
            model = captureD();
        end
        expQ.push_back(model);
        @(posedge clk);
    endtask

    initial begin : monitor
        slot_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("scoreboard", 256'(sampleE()), 256'(e));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required normal completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin : stimulus
        logic [3:0] r;
        reset  = 1'b1;
        StallE = 1'b0;
        FlushE = 1'b0;
        model  = '0;
        clearD();
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 256'(sampleE()), 256'd0);
        reset = 1'b0;

        @(negedge clk);
        bus.ImmExtD   = 32'hFFFFF7BC;
        bus.RD1D      = 32'h0000_0010;
        bus.RdD       = 5'd9;
        bus.RegWriteD = 1'b1;
        bus.ALUSrcD   = 1'b1;
        bus.ValidD    = 1'b1;
        #1;
        checkOutput("no_comb_path", 256'(bus.ImmExtE), 256'd0);
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("pass_imm", 256'(bus.ImmExtE), 256'(32'hFFFFF7BC));
        checkOutput("pass_rd", 256'(bus.RdE), 256'd9);
        checkOutput("pass_valid", 256'(bus.ValidE), 256'd1);

        @(negedge clk);
        clearD();
        bus.ValidD = 1'b1;
        bus.PCD    = 32'h100;
        applyStimulus(1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.PCD = 32'h100 + 32'(4 * k);
            applyStimulus(1'b1, 1'b0);
            #2;
            checkOutput("stall_pc", 256'(bus.PCE), 256'(32'h100));
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("stall_release_pc", 256'(bus.PCE), 256'(32'h10C));

        @(negedge clk);
        clearD();
        bus.ValidD    = 1'b1;
        bus.MemWriteD = 1'b1;
        bus.Rs1D      = 5'd3;
        bus.ImmExtD   = 32'd8;
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("store_loaded", 256'(bus.MemWriteE), 256'd1);
        @(negedge clk);
        randomD();
        bus.ValidD = 1'b1;
        applyStimulus(1'b0, 1'b1);
        #2;
        checkOutput("flush_memwrite", 256'(bus.MemWriteE), 256'd0);
        checkOutput("flush_valid", 256'(bus.ValidE), 256'd0);
        checkOutput("flush_imm", 256'(bus.ImmExtE), 256'd0);

        @(negedge clk);
        clearD();
        bus.ValidD  = 1'b1;
        bus.BranchD = 1'b1;
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        bus.BranchD = 1'b0;
        applyStimulus(1'b1, 1'b0);
        #2;
        checkOutput("branch_held", 256'(bus.BranchE), 256'd1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        #2;
        checkOutput("flush_over_stall_branch", 256'(bus.BranchE), 256'd0);
        checkOutput("flush_over_stall_valid", 256'(bus.ValidE), 256'd0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            randomD();
            bus.ValidD  = 1'b1;
            bus.ImmExtD = 32'(i * 4);
            bus.RdD     = 5'(i);
            applyStimulus(1'b0, 1'b0);
            #2;
            checkOutput("b2b_rd", 256'(bus.RdE), 256'(i));
        end

        @(negedge clk);
        randomD();
        bus.ValidD    = 1'b0;
        bus.RegWriteD = 1'b1;
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("invalid_slot_ctrl", 256'(bus.RegWriteE), 256'd1);
        checkOutput("invalid_slot_valid", 256'(bus.ValidE), 256'd0);

        @(negedge clk);
        randomD();
        bus.ValidD    = 1'b1;
        bus.RegWriteD = 1'b1;
        bus.RdD       = 5'd7;
        applyStimulus(1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 256'(sampleE()), 256'd0);
        model = '0;
        @(negedge clk);
        reset = 1'b0;

        repeat (300) begin
            @(negedge clk);
            randomD();
            r = 4'($urandom);
            applyStimulus(r < 4'd4 || r == 4'd15, r >= 4'd13);
        end

        @(negedge clk);
        StallE = 1'b0;
        FlushE = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("queue_drained", 256'(expQ.size()), 256'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
